// File: rtl/clk_switch_ctrl_pkg.sv
// Shared encodings for the clock-switch sequencer: FSM states and response codes.
// Imported by the sequencer top and its timer.
package clk_switch_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] err_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DESEL = 2'd1;
    localparam state_t ST_SEL   = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    localparam err_t ERR_OK      = 2'd0;
    localparam err_t ERR_BAD_IDX = 2'd1;
    localparam err_t ERR_DEAD    = 2'd2;
    localparam err_t ERR_LOST    = 2'd3;

    // Width needed to hold the larger of the two phase lengths.
    function automatic int timer_width(input int off_cycles, input int on_cycles);
        int m;
        m = (off_cycles > on_cycles) ? off_cycles : on_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_switch_timer.sv
// Loadable down-counter shared by the DESEL and SEL phases.
// expire is high while the count sits at 1, i.e. on the last cycle of a phase.
module clk_switch_timer
    import clk_switch_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count_r;

    // Count register: load wins, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/clk_switch_ctrl.sv
// Clock-switch sequencer driving the one-hot select of a glitch-free clock mux.
// Sequence: deselect-all, drain, select target, settle; reverts if the target dies while settling.
module clk_switch_ctrl
    import clk_switch_ctrl_pkg::*;
#(
    parameter int NUM_CLK     = 4,
    parameter int DEFAULT_IDX = 0,
    parameter int OFF_CYCLES  = 4,
    parameter int ON_CYCLES   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [$clog2(NUM_CLK)-1:0] req_idx,
    input  logic [NUM_CLK-1:0]         clk_alive,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_err,
    output logic [NUM_CLK-1:0]         clk_sel,
    output logic [$clog2(NUM_CLK)-1:0] cur_idx,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_CLK);
    localparam int TMR_W = timer_width(OFF_CYCLES, ON_CYCLES);
    localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(DEFAULT_IDX);
    localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES);
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES);

    function automatic logic [NUM_CLK-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CLK-1:0] code;
        code = {NUM_CLK{1'b0}};
        code[idx] = 1'b1;
        return code;
    endfunction

    state_t               state_r, state_s;
    logic [IDX_W-1:0]     tgt_r, tgt_s;
    logic [IDX_W-1:0]     prev_r, prev_s;
    logic                 lost_r, lost_s;
    logic [IDX_W-1:0]     cur_idx_r, cur_idx_s;
    logic [NUM_CLK-1:0]   clk_sel_r, clk_sel_s;
    logic                 rsp_valid_r, rsp_valid_s;
    err_t                 rsp_err_r, rsp_err_s;

    logic                 bad_idx_s;
    logic                 req_alive_s;
    logic                 tmr_load_s;
    logic [TMR_W-1:0]     tmr_value_s;
    logic                 tmr_expire_s;

    clk_switch_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load_s),
        .value  (tmr_value_s),
        .expire (tmr_expire_s)
    );

    // Out-of-range indices must never reach the clk_alive lookup.
    always_comb begin
        bad_idx_s   = (int'(req_idx) >= NUM_CLK);
        req_alive_s = 1'b0;
        if (bad_idx_s) begin
            req_alive_s = 1'b0;
        end else begin
            req_alive_s = clk_alive[req_idx];
        end
    end

    // Sequencer next-state: request checks, phase timing and lost-clock revert.
    always_comb begin
        state_s     = state_r;
        tgt_s       = tgt_r;
        prev_s      = prev_r;
        lost_s      = lost_r;
        cur_idx_s   = cur_idx_r;
        clk_sel_s   = clk_sel_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = rsp_err_r;
        tmr_load_s  = 1'b0;
        tmr_value_s = OFF_LOAD;

        case (state_r)
            ST_IDLE: begin
                if (!req_valid) begin
                    state_s = ST_IDLE;
                end else if (bad_idx_s) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = ERR_BAD_IDX;
                end else if (!req_alive_s) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = ERR_DEAD;
                end else if (req_idx == cur_idx_r) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = ERR_OK;
                end else begin
                    state_s     = ST_DESEL;
                    tgt_s       = req_idx;
                    prev_s      = cur_idx_r;
                    lost_s      = 1'b0;
                    clk_sel_s   = {NUM_CLK{1'b0}};
                    tmr_load_s  = 1'b1;
                    tmr_value_s = OFF_LOAD;
                end
            end
            ST_DESEL: begin
                if (tmr_expire_s) begin
                    state_s     = ST_SEL;
                    clk_sel_s   = onehot(tgt_r);
                    tmr_load_s  = 1'b1;
                    tmr_value_s = ON_LOAD;
                end else begin
                    clk_sel_s = {NUM_CLK{1'b0}};
                end
            end
            ST_SEL: begin
                // A dying target takes precedence over settling, even on the last cycle.
                if (!lost_r && !clk_alive[tgt_r]) begin
                    state_s     = ST_DESEL;
                    tgt_s       = prev_r;
                    lost_s      = 1'b1;
                    clk_sel_s   = {NUM_CLK{1'b0}};
                    tmr_load_s  = 1'b1;
                    tmr_value_s = OFF_LOAD;
                end else if (tmr_expire_s) begin
                    state_s     = ST_RESP;
                    cur_idx_s   = tgt_r;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = lost_r ? ERR_LOST : ERR_OK;
                end else begin
                    state_s = ST_SEL;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                clk_sel_s = onehot(cur_idx_r);
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tgt_r       <= RST_IDX;
            prev_r      <= RST_IDX;
            lost_r      <= 1'b0;
            cur_idx_r   <= RST_IDX;
            clk_sel_r   <= onehot(RST_IDX);
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= ERR_OK;
        end else begin
            state_r     <= state_s;
            tgt_r       <= tgt_s;
            prev_r      <= prev_s;
            lost_r      <= lost_s;
            cur_idx_r   <= cur_idx_s;
            clk_sel_r   <= clk_sel_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign clk_sel   = clk_sel_r;
    assign cur_idx   = cur_idx_r;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench for clk_switch_ctrl (NUM_CLK=4, DEFAULT_IDX=0, OFF=4, ON=8).
// Stimulus pushes expected responses; a negedge monitor pops them and checks select invariants.
module tb_clk_switch_ctrl;

    localparam int OFF = 4;
    localparam int ON  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_idx = 2'd0;
    logic [3:0] clk_alive = 4'b1111;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [3:0] clk_sel;
    logic [1:0] cur_idx;
    logic       busy;

    typedef struct {
        logic [1:0] err;
        logic [1:0] idx;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    clk_switch_ctrl #(
        .NUM_CLK     (4),
        .DEFAULT_IDX (0),
        .OFF_CYCLES  (OFF),
        .ON_CYCLES   (ON)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .clk_alive (clk_alive),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .clk_sel   (clk_sel),
        .cur_idx   (cur_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N has settled, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: response scoreboard plus per-cycle select invariants.
    initial begin
        exp_t       e;
        logic [3:0] last_nz;
        int         zrun;
        last_nz = 4'b0000;
        zrun    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_nz = 4'b0000;
                zrun    = 0;
            end else begin
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_cur_idx", cur_idx, e.idx);
                        chk("rsp_latency_edge", cyc, e.cyc);
                    end
                end
                chk("sel_onehot0", ($countones(clk_sel) <= 1), 1);
                if (clk_sel != 4'b0000) begin
                    if (last_nz != 4'b0000 && clk_sel != last_nz)
                        chk("sel_zero_gap", (zrun >= OFF), 1);
                    last_nz = clk_sel;
                    zrun    = 0;
                end else begin
                    zrun++;
                end
            end
        end
    end

    // Issue one request from a negedge; t returns the accept edge number, back at a negedge.
    task automatic do_req(input logic [1:0] idx, input logic [1:0] e_err, input logic [1:0] e_idx,
                          input int lat, input bit push, output int t);
        int   waited;
        exp_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_idx   = idx;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_before_accept", req_ready, 1);
        @(posedge clk);
        #1;
        t = cyc;
        if (push) begin
            e.err = e_err;
            e.idx = e_idx;
            e.cyc = t + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic sel_window(input string name, input int from_c, input int to_c, input logic [3:0] exp);
        for (int c = from_c; c <= to_c; c++) begin
            while (cyc < c) @(negedge clk);
            chk(name, clk_sel, exp);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout_pending", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        int nrsp;

        // 1. Reset values, then 10 idle cycles.
        repeat (3) @(negedge clk);
        chk("rst_clk_sel", clk_sel, 4'b0001);
        chk("rst_cur_idx", cur_idx, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 2'd0);
        #2 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_clk_sel", clk_sel, 4'b0001);
            chk("idle_cur_idx", cur_idx, 2'd0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_req_ready", req_ready, 1'b1);
            chk("idle_rsp_valid", rsp_valid, 1'b0);
        end

        // 3a. Same index: immediate OK, select untouched.
        do_req(2'd0, 2'd0, 2'd0, 0, 1'b1, t);
        chk("same_busy_in_resp", busy, 1'b1);
        chk("same_ready_in_resp", req_ready, 1'b0);
        sel_window("same_sel_hold", t, t + 2, 4'b0001);
        wait_drain();

        // 3b. Dead target: DEAD, select untouched.
        clk_alive = 4'b0111;
        do_req(2'd3, 2'd2, 2'd0, 0, 1'b1, t);
        sel_window("dead_sel_hold", t, t + 2, 4'b0001);
        wait_drain();
        clk_alive = 4'b1111;

        // 2. Normal switch 0 -> 2.
        do_req(2'd2, 2'd0, 2'd2, OFF + ON, 1'b1, t);
        sel_window("sw2_zero", t, t + OFF - 1, 4'b0000);
        sel_window("sw2_sel", t + OFF, t + OFF + ON - 1, 4'b0100);
        wait_drain();
        chk("sw2_cur_idx", cur_idx, 2'd2);
        chk("sw2_busy_after", busy, 1'b0);

        // Back to 0 so the lost-clock case starts from the default.
        do_req(2'd0, 2'd0, 2'd0, OFF + ON, 1'b1, t);
        sel_window("sw0_zero", t, t + OFF - 1, 4'b0000);
        sel_window("sw0_sel", t + OFF, t + OFF + ON - 1, 4'b0001);
        wait_drain();

        // 4. Switch 0 -> 1, target dies in SEL cycle 3: revert to 0 with LOST.
        do_req(2'd1, 2'd3, 2'd0, OFF + 3 + OFF + ON, 1'b1, t);
        sel_window("lost_zero1", t, t + OFF - 1, 4'b0000);
        sel_window("lost_sel_fwd", t + OFF, t + OFF + 2, 4'b0010);
        clk_alive = 4'b1101;
        sel_window("lost_zero2", t + OFF + 3, t + OFF + 3 + OFF - 1, 4'b0000);
        sel_window("lost_sel_rev", t + 2 * OFF + 3, t + 2 * OFF + 3 + ON - 1, 4'b0001);
        wait_drain();
        chk("lost_cur_idx", cur_idx, 2'd0);
        clk_alive = 4'b1111;

        // 5. Reset during DESEL of 0 -> 3: no response afterwards.
        do_req(2'd3, 2'd0, 2'd3, OFF + ON, 1'b0, t);
        sel_window("rstmid_zero", t, t + 1, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_clk_sel", clk_sel, 4'b0001);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_cur_idx", cur_idx, 2'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nrsp = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("rstmid_no_rsp", nrsp, 0);
        chk("rstmid_sel_after", clk_sel, 4'b0001);
        chk("rstmid_ready_after", req_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
